// File: rtl/arb_pkg.sv
// Shared types for the priority arbiter.
//   arb_state_t : IDLE (no owner) / BUSY (one owner holds the grant)
//   arb_mode_t  : ARB_FIXED (highest index wins) / ARB_RR (round-robin)
package arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;

endpackage

// File: rtl/priority_onehot.sv
// Combinational highest-set-bit selector.
// Ports:
//   req    in  N  candidate vector
//   onehot out N  one-hot of the highest set bit of req; zero when req == 0
//   valid  out 1  high when req != 0
module priority_onehot #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot,
    output logic         valid
);

    always_comb begin
        onehot = '0;
        // Ascending scan: the last set bit seen (the highest one) wins.
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/priority_arbiter.sv
// N-requester arbiter with a registered one-hot grant.
// The owner keeps the grant while it requests; fixed-priority or round-robin
// selection is chosen at run time, and an optional hold limit pre-empts an
// owner that has held for MAX_HOLD cycles while others are waiting.
// Ports:
//   clk         in  1          rising-edge clock
//   reset       in  1          asynchronous active-high reset
//   req         in  N          request vector
//   mode        in  1          0 = fixed priority (MSB highest), 1 = round-robin
//   grant       out N          registered one-hot grant, zero when idle
//   grant_valid out 1          |grant
//   grant_idx   out clog2(N)   index of the granted requester, 0 when idle
module priority_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 mode,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD <= 1) ? 1 : $clog2(MAX_HOLD);

    // The counter saturates at the pre-emption threshold so that a long solo
    // hold still pre-empts as soon as another requester shows up.
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_SAT  = (MAX_HOLD == 0) ? '1 : HOLD_LAST;

    arb_state_t     state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]  hold_q, hold_d;

    arb_mode_t      mode_sel;
    logic           owner_req;
    logic           others_req;
    logic           preempt;
    logic           arb_en;
    logic [N-1:0]   cand;

    logic [N-1:0]   fix_oh;
    logic           fix_v;
    logic [N-1:0]   rr_in;
    logic [N-1:0]   rr_oh_raw;
    logic           rr_v;
    logic [N-1:0]   rr_oh;
    logic [N-1:0]   win_oh;
    logic [IW-1:0]  win_idx;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
        int s;
        s = (int'(a) + b) % N;
        return IW'(s);
    endfunction

    function automatic logic [IW-1:0] onehot_to_idx(input logic [N-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) r = IW'(i);
        end
        return r;
    endfunction

    assign mode_sel = arb_mode_t'(mode);

    // Arbitration trigger and candidate set.
    always_comb begin
        owner_req  = |(req & grant_q);
        others_req = |(req & ~grant_q);
        preempt    = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && others_req;
        cand       = req;
        arb_en     = 1'b0;
        unique case (state_q)
            IDLE: arb_en = |req;
            BUSY: begin
                if (!owner_req) begin
                    // An owner drop wins over a simultaneous pre-emption.
                    arb_en = |req;
                end else if (preempt) begin
                    arb_en = 1'b1;
                    cand   = req & ~grant_q;
                end
            end
            default: arb_en = 1'b0;
        endcase
    end

    priority_onehot #(.N(N)) u_fix (
        .req    (cand),
        .onehot (fix_oh),
        .valid  (fix_v)
    );

    // Round-robin: rotate so rr_ptr lands at the top bit and the scan order
    // ptr, ptr+1, ... runs downward; the highest-bit selector then yields the
    // first requester at or above rr_ptr. The result is mapped back afterwards.
    always_comb begin
        rr_in = '0;
        for (int j = 0; j < N; j++) begin
            rr_in[N-1-j] = cand[wrap_add(rr_ptr_q, j)];
        end
    end

    priority_onehot #(.N(N)) u_rr (
        .req    (rr_in),
        .onehot (rr_oh_raw),
        .valid  (rr_v)
    );

    always_comb begin
        rr_oh = '0;
        for (int j = 0; j < N; j++) begin
            rr_oh[wrap_add(rr_ptr_q, j)] = rr_oh_raw[N-1-j];
        end
    end

    assign win_oh  = (mode_sel == ARB_RR) ? rr_oh : fix_oh;
    assign win_idx = onehot_to_idx(win_oh);

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        if (arb_en) begin
            state_d = BUSY;
            grant_d = win_oh;
            idx_d   = win_idx;
            hold_d  = '0;
            if (mode_sel == ARB_RR) rr_ptr_d = wrap_add(win_idx, 1);
        end else if (state_q == BUSY) begin
            if (!owner_req) begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
            end else if (hold_q != HOLD_SAT) begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_idx   = idx_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Self-checking bench for priority_arbiter (N=4). Two instances share the
// inputs: one with MAX_HOLD=4 and one with MAX_HOLD=0 (no hold limit).
module tb_priority_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       mode = 1'b0;

    logic [3:0] g4, g0;
    logic       v4, v0;
    logic [1:0] i4, i0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state per instance: owner (-1 = idle), pointer, hold count.
    int m_owner[2];
    int m_ptr[2];
    int m_cnt[2];
    int m_limit[2];

    always #5 clk = ~clk;

    priority_arbiter #(.N(4), .MAX_HOLD(4)) dut4 (
        .clk(clk), .reset(reset), .req(req), .mode(mode),
        .grant(g4), .grant_valid(v4), .grant_idx(i4)
    );

    priority_arbiter #(.N(4), .MAX_HOLD(0)) dut0 (
        .clk(clk), .reset(reset), .req(req), .mode(mode),
        .grant(g0), .grant_valid(v0), .grant_idx(i0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_ptr[m]   = 0;
            m_cnt[m]   = 0;
        end
    endtask

    function automatic int pick(input logic [3:0] c, input bit rr, input int ptr);
        if (rr) begin
            for (int s = 0; s < 4; s++)
                if (c[(ptr + s) % 4]) return (ptr + s) % 4;
        end else begin
            for (int i = 3; i >= 0; i--)
                if (c[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input int m);
        bit         arb = 1'b0;
        logic [3:0] c = req;
        logic [3:0] own;
        int         k;
        own = (m_owner[m] < 0) ? 4'b0000 : 4'(1 << m_owner[m]);
        if (m_owner[m] < 0) begin
            arb = (req != 0);
        end else if ((req & own) == 0) begin
            if (req != 0) arb = 1'b1;
            else m_owner[m] = -1;
        end else if (m_limit[m] != 0 && m_cnt[m] == m_limit[m] - 1 && (req & ~own) != 0) begin
            arb = 1'b1;
            c   = req & ~own;
        end else if (m_limit[m] != 0 && m_cnt[m] < m_limit[m] - 1) begin
            m_cnt[m]++;
        end
        if (arb) begin
            k = pick(c, mode, m_ptr[m]);
            m_owner[m] = k;
            m_cnt[m]   = 0;
            if (mode) m_ptr[m] = (k + 1) % 4;
        end
    endtask

    function automatic logic [3:0] exp_grant(input int m);
        return (m_owner[m] < 0) ? 4'b0000 : 4'(1 << m_owner[m]);
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".g4"}, 32'(g4), 32'(exp_grant(0)));
        check({tag, ".v4"}, 32'(v4), 32'(m_owner[0] >= 0));
        check({tag, ".i4"}, 32'(i4), 32'((m_owner[0] < 0) ? 0 : m_owner[0]));
        check({tag, ".g0"}, 32'(g0), 32'(exp_grant(1)));
        check({tag, ".v0"}, 32'(v0), 32'(m_owner[1] >= 0));
        check({tag, ".i0"}, 32'(i0), 32'((m_owner[1] < 0) ? 0 : m_owner[1]));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (reset) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_async", 32'(g4), 32'h0);
        tick("rst_hold");
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] seq[5];
        logic [3:0] hsb;

        m_limit[0] = 4;
        m_limit[1] = 0;
        model_reset();

        // 1. Reset with all requests pending.
        req = 4'b1111;
        tick("t1_rst");
        tick("t1_rst");
        check("t1_grant", 32'(g4), 32'h0);
        check("t1_valid", 32'(v4), 32'h0);
        check("t1_idx", 32'(i4), 32'h0);
        reset = 1'b0;
        tick("t1_run");
        check("t1_busy", 32'(g4), 32'h8);
        // Reset asserted between edges clears the grant at once.
        #2 reset = 1'b1;
        #1;
        check("t1_async_g", 32'(g4), 32'h0);
        check("t1_async_v", 32'(v4), 32'h0);
        model_reset();
        tick("t1_rst2");
        reset = 1'b0;

        // 2. Fixed priority, owner drop hands over without a bubble.
        mode = 1'b0;
        req  = 4'b1010;
        tick("t2_a");
        check("t2_g3", 32'(g4), 32'h8);
        check("t2_i3", 32'(i4), 32'h3);
        req = 4'b0010;
        tick("t2_b");
        check("t2_g1", 32'(g4), 32'h2);
        req = 4'b0000;
        tick("t2_idle");

        // 3. Round-robin rotation with the owner dropping each time.
        do_reset();
        mode = 1'b1;
        req  = 4'b1111;
        seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int s = 0; s < 5; s++) begin
            tick("t3");
            check("t3_rr", 32'(g4), 32'(seq[s]));
            req = 4'b1111 & ~g4;
        end
        req = 4'b0000;
        tick("t3_idle");

        // 4. Hold-limit pre-emption vs. unlimited hold.
        do_reset();
        mode = 1'b1;
        req  = 4'b0011;
        for (int c = 0; c < 12; c++) begin
            tick("t4");
            check("t4_lim", 32'(g4), 32'(((c / 4) % 2 == 0) ? 4'b0001 : 4'b0010));
            check("t4_nolim", 32'(g0), 32'h1);
        end
        req = 4'b0000;
        tick("t4_idle");

        // 5. Round-robin from rr_ptr = 3.
        do_reset();
        mode = 1'b1;
        req  = 4'b0100;
        tick("t5_setup");
        req = 4'b0000;
        tick("t5_setup2");
        req = 4'b0100;
        tick("t5_a");
        check("t5_g2", 32'(g4), 32'h4);
        req = 4'b0000;
        tick("t5_b");
        check("t5_idle_g", 32'(g4), 32'h0);
        check("t5_idle_v", 32'(v4), 32'h0);
        // rr_ptr must still be 3: 1001 scanned from 3 selects index 3.
        req = 4'b1001;
        tick("t5_c");
        check("t5_ptr", 32'(g4), 32'h8);
        req = 4'b0000;
        tick("t5_d");

        // 6. Fixed-priority sweep from IDLE.
        mode = 1'b0;
        for (int v = 0; v < 16; v++) begin
            req = 4'(v);
            tick("t6");
            hsb = 4'b0000;
            for (int b = 0; b < 4; b++)
                if (v >= (1 << b)) hsb = 4'(1 << b);
            check("t6_sweep", 32'(g4), 32'(hsb));
            req = 4'b0000;
            tick("t6_idle");
        end

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 1) == 0) req = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) mode = ~mode;
                tick("rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
